// File: rtl/mem_access_pkg.sv
// Shared types for the load/store sequencer: access size, FSM states, data width,
// and helpers for size normalisation and alignment checking.
package mem_access_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_WR,
    ST_DONE
  } state_t;

  // Encoding 2'b11 is folded onto word so downstream logic sees only three sizes.
  function automatic size_t norm_size(input logic [1:0] raw);
    case (raw)
      2'b01:   return SIZE_HALF;
      2'b10:   return SIZE_BYTE;
      default: return SIZE_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_t size, input logic [1:0] lane);
    return ((size == SIZE_WORD) && (lane != 2'b00)) ||
           ((size == SIZE_HALF) && lane[0]);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request-side and memory-side signals of the load/store sequencer, plus the
// FSM state exposed for observation.
interface mem_access_ctrl_if;
  import mem_access_pkg::*;

  // Req is a level request sampled only while the sequencer is idle; Busy is high
  // for the whole access and Done pulses for one cycle at its end. The requester
  // must drop Req in the Done cycle, otherwise a new access starts from idle.
  logic             Req;
  logic             ReqWrite;
  logic [1:0]       Size;
  logic             Unsigned;
  logic [WIDTH-1:0] ReqAddr;
  logic [WIDTH-1:0] ReqData;
  logic             Busy;
  logic             Done;
  logic             AlignErr;
  logic [WIDTH-1:0] LoadData;
  logic [WIDTH-1:0] MemAddr;
  logic             MemWr;
  logic [WIDTH-1:0] MemDataOut;
  logic [WIDTH-1:0] MemDataIn;
  state_t           state_dbg;

  modport slave (
    input  Req, ReqWrite, Size, Unsigned, ReqAddr, ReqData, MemDataIn,
    output Busy, Done, AlignErr, LoadData, MemAddr, MemWr, MemDataOut, state_dbg
  );

  modport master (
    output Req, ReqWrite, Size, Unsigned, ReqAddr, ReqData, MemDataIn,
    input  Busy, Done, AlignErr, LoadData, MemAddr, MemWr, MemDataOut, state_dbg
  );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: merges store data into a word for sub-word stores
// and extracts/extends the addressed lane of a read word for loads.
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  size_t            size,
  input  logic [1:0]       lane,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] rd_word,
  output logic [WIDTH-1:0] merged,
  output logic [WIDTH-1:0] extracted
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Little-endian lanes: byte k at [8k+7:8k], half h = lane[1] at [16h+15:16h].
  assign byte_v = rd_word[{lane, 3'b000} +: 8];
  assign half_v = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    merged    = old_word;
    extracted = rd_word;
    case (size)
      SIZE_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wr_data[7:0];
        extracted = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      end
      SIZE_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wr_data[15:0];
        extracted = {{16{~is_unsigned & half_v[15]}}, half_v};
      end
      default: begin
        merged    = wr_data;
        extracted = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the multicycle control unit and a single-port word
// memory. Define MEM_ACCESS_ALIGN_CHECK_EN to enable misalignment detection.
module mem_access_ctrl
  import mem_access_pkg::*;
(
  input logic         Clk,
  input logic         Reset,
  mem_access_ctrl_if.slave bus
);

  state_t           state, state_n;
  logic             write_q;
  logic             uns_q;
  size_t            size_q;
  size_t            size_in;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] extracted;

  assign size_in = norm_size(bus.Size);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q;
  logic align_bad;
  assign align_bad = misaligned(size_in, bus.ReqAddr[1:0]);
`endif

  mem_lane_unit u_lane (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .old_word    (word_q),
    .wr_data     (data_q),
    .rd_word     (bus.MemDataIn),
    .merged      (merged),
    .extracted   (extracted)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SIZE_WORD;
      addr_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
      load_q  <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == ST_IDLE && bus.Req) begin
        write_q <= bus.ReqWrite;
        uns_q   <= bus.Unsigned;
        size_q  <= size_in;
        addr_q  <= bus.ReqAddr;
        data_q  <= bus.ReqData;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        err_q   <= align_bad;
`endif
      end
      // Load result is registered on entry to DONE so it is valid alongside Done.
      if (state == ST_RD2) begin
        word_q <= bus.MemDataIn;
        if (!write_q) load_q <= extracted;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.Req) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
          if (align_bad)                                   state_n = ST_DONE;
          else if (bus.ReqWrite && size_in == SIZE_WORD)   state_n = ST_WR;
          else                                             state_n = ST_RD1;
`else
          if (bus.ReqWrite && size_in == SIZE_WORD)        state_n = ST_WR;
          else                                             state_n = ST_RD1;
`endif
        end
      end
      ST_RD1:  state_n = ST_RD2;
      ST_RD2:  state_n = write_q ? ST_WR : ST_DONE;
      ST_WR:   state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.Busy       = (state != ST_IDLE);
  assign bus.Done       = (state == ST_DONE);
  assign bus.MemWr      = (state == ST_WR);
  assign bus.MemAddr    = {addr_q[WIDTH-1:2], 2'b00};
  assign bus.MemDataOut = merged;
  assign bus.LoadData   = load_q;
  assign bus.state_dbg  = state;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign bus.AlignErr   = err_q & (state == ST_DONE);
`else
  assign bus.AlignErr   = 1'b0;
`endif

endmodule
